// File: rtl/sysbus_pkg.sv
// Shared types and constants for the SysBus external memory sequencer.
package sysbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int MAX_DATA_W      = 64;

    // Sliced down to DATA_W by the user; returned on a timed-out read.
    localparam logic [MAX_DATA_W-1:0] READ_ERR_DATA = '1;

    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sysbus_mem_if_bus_timer.sv
// Wait-state timer for the STROBE phase: clearable up-counter that stops at
// its terminal count TIMEOUT-1.
module bus_timer
    import sysbus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int             W      = timer_width(TIMEOUT);
    localparam logic [W-1:0]   TC_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_tc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/sysbus_mem_if.sv
// Memory-bus sequencer: captures address/store data from SysBus, runs a
// strobed wait-state RAM cycle and returns read data on DataIn.
module sysbus_mem_if
    import sysbus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_sysbus,
    output logic [DATA_W-1:0] o_data_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bus_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_n_me,
    output logic              o_n_oe,
    output logic              o_n_we
);

    state_t            r_state;
    logic              r_wr;
    logic [DATA_W-1:0] r_data_in;
    logic              r_busy;
    logic              r_done;
    logic              r_bus_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_n_me;
    logic              r_n_oe;
    logic              r_n_we;

    logic              w_timer_clr;
    logic              w_timer_en;
    logic              w_tc;

    assign w_timer_clr = (r_state == ST_SETUP);
    assign w_timer_en  = (r_state == ST_STROBE) && !i_mem_ready;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .o_tc     (w_tc)
    );

    // Outputs are registered against the next state so the strobes track the
    // state exactly and never glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_data_in   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_n_me      <= 1'b1;
            r_n_oe      <= 1'b1;
            r_n_we      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_n_me <= 1'b1;
                    r_n_oe <= 1'b1;
                    r_n_we <= 1'b1;
                    if (i_req) begin
                        r_mem_addr <= ADDR_W'(i_sysbus);
                        r_wr       <= i_wr;
                        r_bus_err  <= 1'b0;
                        r_busy     <= 1'b1;
                        if (i_wr) begin
                            r_state <= ST_WDATA;
                        end else begin
                            r_state <= ST_SETUP;
                            r_n_me  <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WDATA: begin
                    r_mem_wdata <= i_sysbus;
                    r_state     <= ST_SETUP;
                    r_n_me      <= 1'b0;
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_n_oe  <= r_wr;
                    r_n_we  <= !r_wr;
                end
                ST_STROBE: begin
                    // Ready wins over the terminal count in the same cycle.
                    if (i_mem_ready || w_tc) begin
                        if (!i_mem_ready) begin
                            r_bus_err <= 1'b1;
                        end
                        if (!r_wr) begin
                            r_data_in <= i_mem_ready ? i_mem_rdata
                                                     : READ_ERR_DATA[DATA_W-1:0];
                        end
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_n_me  <= 1'b1;
                        r_n_oe  <= 1'b1;
                        r_n_we  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_n_me  <= 1'b1;
                    r_n_oe  <= 1'b1;
                    r_n_we  <= 1'b1;
                end
            endcase
        end
    end

    assign o_data_in   = r_data_in;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_bus_err   = r_bus_err;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_n_me      = r_n_me;
    assign o_n_oe      = r_n_oe;
    assign o_n_we      = r_n_we;

endmodule

// File: tb/tb_sysbus_mem_if.sv
// Directed and randomized bench for sysbus_mem_if with a transaction-level
// memory/timing model.
module tb_sysbus_mem_if;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [15:0] sysbus;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] o_data_in;
    logic        o_busy;
    logic        o_done;
    logic        o_bus_err;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_n_me;
    logic        o_n_oe;
    logic        o_n_we;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_dout;

    always #5 clk = ~clk;

    sysbus_mem_if #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_wr        (wr),
        .i_sysbus    (sysbus),
        .o_data_in   (o_data_in),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bus_err   (o_bus_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_n_me      (o_n_me),
        .o_n_oe      (o_n_oe),
        .o_n_we      (o_n_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hC3A5;
    endfunction

    // Starts at a point #1 after an edge; returns #1 after the edge entering DONE.
    // t_wait = MemReady-low STROBE cycles before ready (>= TIMEOUT: never ready).
    task automatic do_txn(input bit t_wr, input logic [15:0] t_addr,
                          input logic [15:0] t_data, input int t_wait);
        int cyc, k, me_lo, oe_lo, we_lo, strobes, exp_cyc;
        bit found, tmo;
        logic [15:0] rd;
        tmo     = (t_wait >= TIMEOUT);
        strobes = tmo ? TIMEOUT : t_wait + 1;
        exp_cyc = (t_wr ? 4 : 3) + strobes - 1;
        rd      = mem_val(t_addr);

        req = 1'b1; wr = t_wr; sysbus = t_addr;
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        req = 1'b0; wr = 1'($urandom);
        sysbus = t_wr ? t_data : 16'($urandom);
        chk("accept_busy", 32'(o_busy), 32'd1);
        chk("accept_err_clr", 32'(o_bus_err), 32'd0);
        chk("mem_addr", 32'(o_mem_addr), 32'(t_addr));

        cyc = 1; k = 0; found = 0; me_lo = 0; oe_lo = 0; we_lo = 0;
        while (!found && cyc < 64) begin
            if (o_done) begin
                found = 1;
            end else begin
                if (!o_n_me) me_lo++;
                if (!o_n_oe) oe_lo++;
                if (!o_n_we) we_lo++;
                chk("oe_we_excl", 32'(o_n_oe | o_n_we), 32'd1);
                if (!o_n_oe || !o_n_we) begin
                    mem_ready = (k == t_wait);
                    mem_rdata = rd;
                    k++;
                end else begin
                    mem_ready = 1'($urandom);
                    mem_rdata = 16'($urandom);
                end
                @(posedge clk); #1;
                if (cyc == 1) sysbus = 16'($urandom);
                cyc++;
            end
        end

        chk("done_seen", 32'(found), 32'd1);
        if (!t_wr) exp_dout = tmo ? 16'hFFFF : rd;
        else if (!tmo) mem[t_addr] = t_data;
        if (found) begin
            chk("latency", 32'(cyc), 32'(exp_cyc));
            chk("bus_err", 32'(o_bus_err), 32'(tmo));
            chk("data_in", 32'(o_data_in), 32'(exp_dout));
            chk("busy_in_done", 32'(o_busy), 32'd1);
            chk("strobes_off_done", 32'({o_n_me, o_n_oe, o_n_we}), 32'd7);
            chk("nme_cycles", 32'(me_lo), 32'(strobes + 1));
            chk("noe_cycles", 32'(oe_lo), t_wr ? 32'd0 : 32'(strobes));
            chk("nwe_cycles", 32'(we_lo), t_wr ? 32'(strobes) : 32'd0);
            if (t_wr) chk("mem_wdata", 32'(o_mem_wdata), 32'(t_data));
        end
    endtask

    task automatic idle_step();
        req = 1'b0; wr = 1'($urandom); sysbus = 16'($urandom);
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, sel;
        rst = 1'b1; req = 1'b0; wr = 1'b0; sysbus = '0;
        mem_ready = 1'b0; mem_rdata = '0; exp_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_in", 32'(o_data_in), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_bus_err", 32'(o_bus_err), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
        chk("rst_strobes", 32'({o_n_me, o_n_oe, o_n_we}), 32'd7);
        rst = 1'b0;
        idle_step();

        // Zero-wait read
        mem[16'h1234] = 16'hBEEF;
        do_txn(1'b0, 16'h1234, 16'h0000, 0);
        idle_step();

        // Write with two waits, then read it back
        do_txn(1'b1, 16'h00A0, 16'h5A5A, 2);
        idle_step();
        do_txn(1'b0, 16'h00A0, 16'h0000, 0);
        idle_step();

        // Timeouts; the following request clears BusErr
        do_txn(1'b0, 16'h0300, 16'h0000, 1000);
        do_txn(1'b0, 16'h0301, 16'h0000, 1);
        idle_step();
        do_txn(1'b1, 16'h0302, 16'h1111, TIMEOUT);
        idle_step();

        // Back-to-back requests
        do_txn(1'b0, 16'h0001, 16'h0000, 0);
        do_txn(1'b0, 16'h0002, 16'h0000, 0);
        idle_step();

        // Reset during STROBE of a write
        req = 1'b1; wr = 1'b1; sysbus = 16'h0040;
        @(posedge clk); #1;
        req = 1'b0; sysbus = 16'h7777; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_nwe", 32'(o_n_we), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_nme", 32'(o_n_me), 32'd1);
        chk("mid_rst_nwe", 32'(o_n_we), 32'd1);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_data_in", 32'(o_data_in), 32'd0);
        exp_dout = '0;
        rst = 1'b0;
        idle_step();

        // Ready arrives in the last STROBE cycle before timeout
        do_txn(1'b0, 16'h0777, 16'h0000, TIMEOUT - 1);
        idle_step();

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       w = int'($urandom_range(0, 3));
            else if (sel == 6) w = TIMEOUT - 1;
            else if (sel == 7) w = TIMEOUT;
            else if (sel == 8) w = 200;
            else               w = int'($urandom_range(4, TIMEOUT - 2));
            do_txn(1'($urandom), 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom), w);
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_if.md
Name: sysbus_mem_if

Overview:
- Memory-bus sequencer directly downstream of the datapath's SysBus output; upstream of its DataIn input.
- On a control-unit request, captures the address (and, for writes, the store data) from SysBus.
- Runs a strobed, wait-state-capable external RAM cycle and returns read data on DataIn.
- Reports Busy, Done and BusErr to the control FSM so it can stall.

Parameters:
- ADDR_W, 16, external address width; equals the SysBus width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum STROBE cycles without MemReady before the cycle aborts; range 1..255.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  control: start a memory cycle. Sampled only in IDLE or DONE.
- Wr  in  1  control: 1 = write, 0 = read. Sampled with Req.
- SysBus  in  DATA_W  datapath bus. Carries the address in the Req cycle; carries the store data in the cycle after Req for writes.
- DataIn  out  DATA_W  read data to the datapath. Registered, held until the next read completes.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a cycle completes.
- BusErr  out  1  high with Done when the cycle timed out. Cleared on the next accepted Req.
- MemAddr  out  ADDR_W  external address, registered.
- MemWData  out  DATA_W  external write data, registered.
- MemRData  in  DATA_W  external read data.
- MemReady  in  1  memory ready. Sampled in STROBE only.
- nME  out  1  active-low chip enable.
- nOE  out  1  active-low output enable, reads.
- nWE  out  1  active-low write enable, writes.

Behaviour:
- Reset values: DataIn=0, Busy=0, Done=0, BusErr=0, MemAddr=0, MemWData=0, nME=nOE=nWE=1, state=IDLE, timer=0.
- Reset mid-cycle: all strobes deassert at that edge, no Done is issued, DataIn is cleared.
- States: IDLE, WDATA, SETUP, STROBE, DONE.
- IDLE or DONE with Req=1:
  - MemAddr<=SysBus, latched Wr stored, BusErr<=0.
  - Next state is WDATA if Wr=1, else SETUP.
- IDLE with Req=0: stay in IDLE.
- DONE with Req=0: go to IDLE. Done is high only while in DONE, so back-to-back requests are supported.
- WDATA: MemWData<=SysBus; next state SETUP. Strobes stay high.
- SETUP: nME=0, nOE=nWE=1; timer<=0; next state STROBE. Provides one cycle of address setup.
- STROBE:
  - nME=0; nOE=0 for reads, nWE=0 for writes.
  - If MemReady=1: reads capture DataIn<=MemRData; next state DONE.
  - Else if timer==TIMEOUT-1: BusErr<=1; reads set DataIn<=all ones; next state DONE.
  - Else: timer increments; stay in STROBE.
  - MemReady takes priority over timeout in the same cycle.
- DONE: nME=nOE=nWE=1; Done=1. Writes leave DataIn unchanged.
- Latency, counted from the Req cycle with MemReady already high:
  - Read: Done is high in cycle 3.
  - Write: Done is high in cycle 4.
  - Each MemReady-low STROBE cycle adds 1.
- Strobe outputs are registered, so they are glitch-free. nOE and nWE are never low simultaneously.
- Req while in WDATA, SETUP or STROBE is ignored. Wr is don't-care when Req=0.
- The timer is ceil(log2(TIMEOUT+1)) bits wide and never wraps: it saturates at TIMEOUT-1 via the abort.

Decomposition:
- Shared package sysbus_pkg holds:
  - the state enum (IDLE, WDATA, SETUP, STROBE, DONE);
  - DEFAULT_TIMEOUT=15;
  - the READ_ERR_DATA constant (all ones).
- One natural sub-module: bus_timer.
  - Function: clearable up-counter with a terminal-count flag.
  - Ports: clear, enable, tc; TIMEOUT is passed down as a parameter.
- The FSM and datapath registers stay in sysbus_mem_if.

Test Plan:
1. Read, zero wait: Req=1, Wr=0, SysBus=16'h1234; memory holds 16'hBEEF with MemReady=1 → MemAddr=16'h1234; nME low for 2 cycles, nOE low 1 cycle; Done in cycle 3; DataIn=16'hBEEF; BusErr=0.
2. Write, 2 waits: Req=1, Wr=1, SysBus=16'h00A0, then SysBus=16'h5A5A; MemReady low 2 STROBE cycles → MemWData=16'h5A5A; nWE low 3 cycles; Done in cycle 6; DataIn unchanged.
3. Timeout: read with MemReady held 0 → nOE low exactly 15 cycles; Done with BusErr=1; DataIn=16'hFFFF. A following Req clears BusErr.
4. Back-to-back: Req held high during DONE with a new address 16'h0002 → the second cycle starts without an IDLE cycle; Done pulses at cycles 3 and 6.
5. Reset mid-cycle: Reset=1 during STROBE of a write → at the next edge nME=nWE=1, Busy=0, no Done, DataIn=0.
6. Ready vs timeout race: MemReady=1 exactly in STROBE cycle 15 → normal completion, BusErr=0, DataIn=MemRData.
